// File: rtl/xnor_serial_cmp.sv
// ---------------------------------------------------------------------------
// xnor_serial_cmp
//
// Bit-serial XNOR comparator. Two WIDTH-bit operands are captured on an
// accepted start and then compared one bit per clock, LSB first. It produces:
//   - the per-bit XNOR vector
//   - the number of matching bits
//   - an equality flag
//   - the index of the lowest mismatching bit
// A start/busy/done handshake connects it to a controlling FSM.
//
// Optional feature macro: XNOR_CMP_EARLY_EXIT_EN
//   When defined, the scan stops at the first mismatching bit and goes
//   straight to DONE. Bits that were not processed stay 0 in xnor_vec.
//   When undefined, all WIDTH bits are always scanned.
//
// Parameters:
//   WIDTH  operand width in bits (1..64)
//   CNT_W  width of match_cnt, large enough to hold WIDTH
//   IDX_W  width of mismatch_idx
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   start         comparison request, only looked at while idle
//   a, b          operands, captured on the accepted start edge
//   busy          high while a comparison is running or reporting
//   done          one-cycle pulse when the results are valid
//   xnor_vec      bit i = ~(a[i] ^ b[i]) of the captured operands
//   match_cnt     number of ones in xnor_vec
//   equal         high when every bit matched
//   mismatch_idx  lowest index where a and b differ, 0 when equal
// ---------------------------------------------------------------------------
module xnor_serial_cmp #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] xnor_vec,
  output logic [CNT_W-1:0] match_cnt,
  output logic             equal,
  output logic [IDX_W-1:0] mismatch_idx
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDX_W-1:0] bit_idx;
  logic             found;

  logic             bit_x;
  logic [CNT_W-1:0] cnt_next;

  // The bit under test always sits at position 0 of the shift registers.
  // cnt_next is the match count including this bit. The equality decision
  // on the final edge needs it, because match_cnt itself is one bit behind.
  assign bit_x    = ~(sa[0] ^ sb[0]);
  assign cnt_next = match_cnt + CNT_W'(bit_x);

  // Main sequencer.
  // Reset takes priority over everything and discards any comparison that
  // is in flight.
  // In RUN, each edge retires one bit. The edge that retires the last bit,
  // or the first mismatch in early-exit builds, raises done for exactly
  // one cycle.
  // The results are left alone in DONE and IDLE. They are only cleared
  // when the next start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      xnor_vec     <= '0;
      match_cnt    <= '0;
      mismatch_idx <= '0;
      sa           <= '0;
      sb           <= '0;
      bit_idx      <= '0;
      found        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa           <= a;
            sb           <= b;
            xnor_vec     <= '0;
            match_cnt    <= '0;
            mismatch_idx <= '0;
            equal        <= 1'b0;
            found        <= 1'b0;
            bit_idx      <= '0;
            busy         <= 1'b1;
            state        <= ST_RUN;
          end
        end

        ST_RUN: begin
          xnor_vec[bit_idx] <= bit_x;
          match_cnt         <= cnt_next;
          sa                <= sa >> 1;
          sb                <= sb >> 1;
          bit_idx           <= bit_idx + IDX_W'(1);

          if (bit_idx == LAST_IDX) begin
            state <= ST_DONE;
            done  <= 1'b1;
            equal <= (cnt_next == FULL_CNT);
          end

          // Only the lowest mismatching index is recorded. The found flag
          // stops later mismatches from overwriting it.
          if (!bit_x && !found) begin
            mismatch_idx <= bit_idx;
            found        <= 1'b1;
`ifdef XNOR_CMP_EARLY_EXIT_EN
            state        <= ST_DONE;
            done         <= 1'b1;
            equal        <= 1'b0;
`endif
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_serial_cmp.sv
// ---------------------------------------------------------------------------
// tb_xnor_serial_cmp
//
// Self-checking bench for xnor_serial_cmp with WIDTH = 8.
// Expected results come from a loop-based reference model. They are pushed
// onto a scoreboard queue when a start is driven, and popped when done is
// seen. The model follows XNOR_CMP_EARLY_EXIT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_xnor_serial_cmp;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef struct {
    logic [WIDTH-1:0] xv;
    logic [CNT_W-1:0] cnt;
    logic             eq;
    logic [IDX_W-1:0] idx;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] xnor_vec;
  logic [CNT_W-1:0] match_cnt;
  logic             equal;
  logic [IDX_W-1:0] mismatch_idx;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  xnor_serial_cmp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .xnor_vec(xnor_vec), .match_cnt(match_cnt),
    .equal(equal), .mismatch_idx(mismatch_idx)
  );

  // Free-running clock and a cycle counter used for interval checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: walks the operand bits from LSB to MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
    exp_t e;
    bit   found;
    bit   stop;
    e.xv = '0; e.cnt = '0; e.eq = 1'b0; e.idx = '0; e.lat = WIDTH;
    found = 1'b0; stop = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!stop) begin
        e.xv[i] = ~(ma[i] ^ mb[i]);
        if (e.xv[i]) e.cnt = e.cnt + 1'b1;
        else if (!found) begin
          found = 1'b1;
          e.idx = IDX_W'(i);
`ifdef XNOR_CMP_EARLY_EXIT_EN
          e.lat = i + 1;
          stop = 1'b1;
`endif
        end
      end
    end
    e.eq = (e.cnt == CNT_W'(WIDTH));
    return e;
  endfunction

  // Called just after a clock edge. The next edge captures the operands.
  task automatic drive_start(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
    a = da; b = db; start = 1'b1;
    sb_q.push_back(model(da, db));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen. Gives up after a bounded number of cycles.
  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    while (!ok && lat < 4 * WIDTH + 8) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int dcount;
    int lat;
    bit ok;
    exp_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, equal, xnor_vec, match_cnt, mismatch_idx} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b eq=%b xv=%h cnt=%0d idx=%0d, expected all zero",
               busy, done, equal, xnor_vec, match_cnt, mismatch_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Start a comparison, then reset it while it is in RUN.
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({busy, done, equal, xnor_vec, match_cnt, mismatch_idx} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b eq=%b xv=%h cnt=%0d idx=%0d, expected all zero",
               busy, done, equal, xnor_vec, match_cnt, mismatch_idx);
    end
    dcount = 0;
    repeat (WIDTH + 2) begin @(posedge clk); #1; if (done || busy) dcount++; end
    tests_run++;
    if (dcount != 0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_no_done: got %0d busy/done cycles, expected 0", dcount);
    end
    // A fresh start after the reset must complete normally.
    drive_start(8'hC3, 8'hC3);
    wait_done(lat, ok);
    e = sb_q.pop_front();
    tests_run++;
    if (!ok || lat != e.lat || xnor_vec !== e.xv || match_cnt !== e.cnt || equal !== e.eq) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_compare: got ok=%b lat=%0d xv=%h cnt=%0d eq=%b, expected lat=%0d xv=%h cnt=%0d eq=%b",
               ok, lat, xnor_vec, match_cnt, equal, e.lat, e.xv, e.cnt, e.eq);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_patterns();
    logic [WIDTH-1:0] pa[6] = '{8'h3C, 8'h00, 8'b1010_1100, 8'h80, 8'hFF, 8'h12};
    logic [WIDTH-1:0] pb[6] = '{8'h3C, 8'hFF, 8'b1010_0100, 8'h00, 8'hFE, 8'h34};
    logic [WIDTH-1:0] ta;
    logic [WIDTH-1:0] tb;
    int   lat;
    bit   ok;
    exp_t e;
    for (int n = 0; n < 22; n++) begin
      if (n < 6) begin ta = pa[n]; tb = pb[n]; end
      else begin ta = WIDTH'($urandom); tb = (n % 3 == 0) ? ta : WIDTH'($urandom); end
      drive_start(ta, tb);
      wait_done(lat, ok);
      e = sb_q.pop_front();
      tests_run++;
      if (!ok || lat != e.lat) begin
        tests_failed++;
        $display("[TB] FAIL latency a=%h b=%h: got ok=%b lat=%0d, expected %0d", ta, tb, ok, lat, e.lat);
      end
      tests_run++;
      if (xnor_vec !== e.xv || match_cnt !== e.cnt) begin
        tests_failed++;
        $display("[TB] FAIL vec_cnt a=%h b=%h: got xv=%h cnt=%0d, expected xv=%h cnt=%0d", ta, tb, xnor_vec, match_cnt, e.xv, e.cnt);
      end
      tests_run++;
      if (equal !== e.eq || mismatch_idx !== e.idx || busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL eq_idx a=%h b=%h: got eq=%b idx=%0d busy=%b, expected eq=%b idx=%0d busy=1",
                 ta, tb, equal, mismatch_idx, busy, e.eq, e.idx);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || xnor_vec !== e.xv || match_cnt !== e.cnt) begin
        tests_failed++;
        $display("[TB] FAIL hold a=%h b=%h: got done=%b busy=%b xv=%h cnt=%0d, expected done=0 busy=0 xv=%h cnt=%0d",
                 ta, tb, done, busy, xnor_vec, match_cnt, e.xv, e.cnt);
      end
    end
  endtask

  task automatic test_handshake();
    int   lat;
    int   bcount;
    bit   ok;
    exp_t e;
    drive_start(8'h5A, 8'h4B);
    repeat (2) begin @(posedge clk); #1; end
    // Start pulse and operand changes in the middle of RUN must be ignored.
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, ok);
    e = sb_q.pop_front();
    tests_run++;
    if (!ok || lat + 3 != e.lat || xnor_vec !== e.xv || match_cnt !== e.cnt || mismatch_idx !== e.idx) begin
      tests_failed++;
      $display("[TB] FAIL hs_run_ignore: got ok=%b lat=%0d xv=%h cnt=%0d idx=%0d, expected lat=%0d xv=%h cnt=%0d idx=%0d",
               ok, lat + 3, xnor_vec, match_cnt, mismatch_idx, e.lat, e.xv, e.cnt, e.idx);
    end
    // A start pulse during DONE must be dropped, not queued.
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    bcount = 0;
    repeat (3) begin if (busy || done) bcount++; @(posedge clk); #1; end
    tests_run++;
    if (bcount != 0 || xnor_vec !== e.xv) begin
      tests_failed++;
      $display("[TB] FAIL hs_done_ignore: got %0d busy cycles xv=%h, expected 0 busy cycles xv=%h", bcount, xnor_vec, e.xv);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] qa[4] = '{8'h3C, 8'b1010_1100, 8'h00, 8'hE7};
    logic [WIDTH-1:0] qb[4] = '{8'h3C, 8'b1010_0100, 8'hFF, 8'hE7};
    int   lat;
    int   prev;
    bit   ok;
    exp_t e;
    prev = 0;
    a = qa[0]; b = qb[0]; start = 1'b1;
    sb_q.push_back(model(qa[0], qb[0]));
    for (int k = 0; k < 4; k++) begin
      wait_done(lat, ok);
      e = sb_q.pop_front();
      tests_run++;
      if (!ok || xnor_vec !== e.xv || match_cnt !== e.cnt || equal !== e.eq || mismatch_idx !== e.idx) begin
        tests_failed++;
        $display("[TB] FAIL b2b_result %0d: got ok=%b xv=%h cnt=%0d eq=%b idx=%0d, expected xv=%h cnt=%0d eq=%b idx=%0d",
                 k, ok, xnor_vec, match_cnt, equal, mismatch_idx, e.xv, e.cnt, e.eq, e.idx);
      end
      if (k > 0) begin
        tests_run++;
        if (cyc - prev != e.lat + 2) begin
          tests_failed++;
          $display("[TB] FAIL b2b_interval %0d: got %0d cycles, expected %0d", k, cyc - prev, e.lat + 2);
        end
      end
      prev = cyc;
      if (k < 3) begin
        a = qa[k+1]; b = qb[k+1];
        sb_q.push_back(model(qa[k+1], qb[k+1]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain: got queue=%0d busy=%b, expected queue=0 busy=0", sb_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_handshake();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
